// File: rtl/handshake_master_tx.sv
// Transmit side of the valid/ready byte handshake: producer FIFO feeding a registered output stage.
// Optional stall watchdog (stall_err port) is built only when HS_TIMEOUT_EN is defined.
module handshake_master_tx #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  output logic                       ovf_err,
  output logic                       valid,
  output logic [DATA_W-1:0]          data_out,
  input  logic                       ready,
`ifdef HS_TIMEOUT_EN
  output logic [$clog2(DEPTH):0]     level,
  output logic                       stall_err
`else
  output logic [$clog2(DEPTH):0]     level
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level_q;
  logic               push, pop;

  assign level = level_q;
  assign full  = (level_q == LVL_W'(DEPTH));
  assign push  = wr_en && !full;
  assign valid = (state == SEND);

  // Pops only read entries committed on an earlier edge, so a fresh push never falls through.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (level_q != '0) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (ready) begin
          if (level_q != '0) pop = 1'b1;
          else               state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      ovf_err  <= 1'b0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        data_out <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      // A push against a full FIFO is lost even if a pop frees a slot this same edge.
      if (wr_en && full) ovf_err <= 1'b1;
    end
  end

`ifdef HS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else if (valid && !ready) begin
      if (stall_cnt != CNT_W'(TIMEOUT)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (stall_cnt >= CNT_W'(TIMEOUT - 1)) stall_err <= 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_handshake_master_tx.sv
// Directed bench for handshake_master_tx; stall watchdog scenario runs only when HS_TIMEOUT_EN is defined.
module tb_handshake_master_tx;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              full, ovf_err, valid;
  logic [DATA_W-1:0] data_out;
  logic              ready = 1'b0;
  logic [LVL_W-1:0]  level;
`ifdef HS_TIMEOUT_EN
  logic              stall_err;
`endif

  int vectors = 0;
  int errors  = 0;

  handshake_master_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .ovf_err  (ovf_err),
    .valid    (valid),
    .data_out (data_out),
    .ready    (ready),
`ifdef HS_TIMEOUT_EN
    .level    (level),
    .stall_err(stall_err)
`else
    .level    (level)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b1; wr_data = 8'h55; ready = 1'b0;
    step();
    step();
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    vectors++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    vectors++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
    vectors++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_err); end
    vectors++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
`ifdef HS_TIMEOUT_EN
    vectors++; if (stall_err !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_err); end
`endif
    wr_en = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    ready = 1'b1; wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL single_no_fallthrough: got valid %b want 0", valid); end
    vectors++; if (level !== 3'd1) begin errors++; $display("FAIL single_level1: got %0d want 1", level); end
    step();
    vectors++; if (valid !== 1'b1 || data_out !== 8'hA5) begin errors++; $display("FAIL single_out: got %b/%h want 1/a5", valid, data_out); end
    step();
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL single_done: got valid %b want 0", valid); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] seq [3];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = seq[i];
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (valid !== 1'b1 || data_out !== 8'h11) begin
        errors++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/11", i, valid, data_out);
      end
    end
    vectors++; if (level !== 3'd2) begin errors++; $display("FAIL bp_level: got %0d want 2", level); end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (valid !== 1'b1 || data_out !== seq[i]) begin
        errors++; $display("FAIL bp_drain[%0d]: got %b/%h want 1/%h", i, valid, data_out, seq[i]);
      end
      step();
    end
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_end: got valid %b want 0", valid); end
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    vectors++; if (full !== 1'b1 || level !== 3'd4) begin errors++; $display("FAIL ovf_full: got full %b level %0d want 1/4", full, level); end
    vectors++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", ovf_err); end
    wr_data = 8'h06;
    step();
    wr_en = 1'b0;
    vectors++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf_err); end
    vectors++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", level); end
    ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      vectors++;
      if (valid !== 1'b1 || data_out !== 8'(i)) begin
        errors++; $display("FAIL ovf_drain[%0d]: got %b/%h want 1/%h", i, valid, data_out, 8'(i));
      end
      step();
    end
    vectors++; if (valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL ovf_end: got %b/%0d want 0/0", valid, level); end
    vectors++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf_err); end
  endtask

  task automatic test_mid_reset();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'hA1 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    vectors++; if (level !== 3'd3 || valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got level %0d valid %b want 3/1", level, valid); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    vectors++; if (valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL mid_rst: got %b/%0d want 0/0", valid, level); end
    vectors++; if (ovf_err !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL mid_rst_clr: got %b/%h want 0/00", ovf_err, data_out); end
    ready = 1'b1; wr_en = 1'b1; wr_data = 8'h7E;
    step();
    wr_en = 1'b0;
    vectors++; if (valid !== 1'b0 || level !== 3'd1) begin errors++; $display("FAIL mid_push: got %b/%0d want 0/1", valid, level); end
    step();
    vectors++; if (valid !== 1'b1 || data_out !== 8'h7E || level !== 3'd0) begin errors++; $display("FAIL mid_out: got %b/%h/%0d want 1/7e/0", valid, data_out, level); end
    step();
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_alone: got valid %b want 0", valid); end
  endtask

`ifdef HS_TIMEOUT_EN
  task automatic test_stall();
    ready = 1'b0; wr_en = 1'b1; wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    step();
    vectors++; if (valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", valid); end
    for (int i = 0; i < 15; i++) step();
    vectors++; if (stall_err !== 1'b0) begin errors++; $display("FAIL stall_early: got %b want 0", stall_err); end
    step();
    vectors++; if (stall_err !== 1'b1) begin errors++; $display("FAIL stall_set: got %b want 1", stall_err); end
    vectors++; if (data_out !== 8'h3C) begin errors++; $display("FAIL stall_data: got %h want 3c", data_out); end
    ready = 1'b1;
    step();
    step();
    vectors++; if (stall_err !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL stall_sticky: got %b/%b want 1/0", stall_err, valid); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    vectors++; if (stall_err !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b want 0", stall_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_mid_reset();
`ifdef HS_TIMEOUT_EN
    test_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
